// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-N demux and its round-robin scheduler.
package demux_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_lane_pick.sv
// Combinational circular priority finder: first enabled lane at or after ptr,
// plus whether that lane is the highest enabled one.
module rr_lane_pick
  import demux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sel_w(N)
) (
  input  logic [N-1:0]  lane_en,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] pick,
  output logic          any,
  output logic          is_last
);

  logic          found_s;
  logic [SW-1:0] hi_s;

  // circular search from ptr, and highest set bit of the mask
  always_comb begin
    found_s = 1'b0;
    pick    = {SW{1'b0}};
    hi_s    = {SW{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (!found_s && lane_en[(int'(ptr) + k) % N]) begin
        pick    = SW'((int'(ptr) + k) % N);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (lane_en[i]) begin
        hi_s = SW'(i);
      end else begin
        hi_s = hi_s;
      end
    end
  end

  assign any     = |lane_en;
  assign is_last = any && (pick == hi_s);

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin sequencer feeding a 1-to-N demux: accepts serial bits over
// valid/ready and routes each to the next enabled lane for HOLD cycles.
module demux_rr_scheduler
  import demux_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int HOLD      = 1,
  localparam int SEL_WIDTH = sel_w(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  input  logic                 s_data,
  output logic                 s_ready,
  input  logic [N-1:0]         lane_en,
  output logic                 in,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 strobe,
  output logic                 frame_done
);

  localparam int CW = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);

  state_t               state_r, state_nxt_s;
  logic [SEL_WIDTH-1:0] ptr_r, ptr_nxt_s;
  logic [CW-1:0]        cnt_r, cnt_nxt_s;
  logic                 in_nxt_s, strobe_nxt_s, frame_done_nxt_s;
  logic [SEL_WIDTH-1:0] sel_nxt_s;
  logic [SEL_WIDTH-1:0] pick_s;
  logic                 any_s, is_last_s, accept_s;

  rr_lane_pick #(.N(N), .SW(SEL_WIDTH)) u_pick (
    .lane_en (lane_en),
    .ptr     (ptr_r),
    .pick    (pick_s),
    .any     (any_s),
    .is_last (is_last_s)
  );

  assign s_ready  = any_s && ((state_r == IDLE) || (cnt_r == {CW{1'b0}}));
  assign accept_s = s_valid && s_ready;

  // next-state and next-output decode
  always_comb begin
    state_nxt_s      = state_r;
    ptr_nxt_s        = ptr_r;
    cnt_nxt_s        = cnt_r;
    in_nxt_s         = in;
    sel_nxt_s        = sel;
    strobe_nxt_s     = strobe;
    frame_done_nxt_s = 1'b0;
    if (accept_s) begin
      state_nxt_s      = DRIVE;
      in_nxt_s         = s_data;
      sel_nxt_s        = pick_s;
      strobe_nxt_s     = 1'b1;
      cnt_nxt_s        = CW'(HOLD - 1);
      frame_done_nxt_s = is_last_s;
      ptr_nxt_s        = (pick_s == SEL_WIDTH'(N - 1)) ? {SEL_WIDTH{1'b0}}
                                                       : pick_s + SEL_WIDTH'(1);
    end else begin
      case (state_r)
        IDLE: begin
          frame_done_nxt_s = 1'b0;
        end
        DRIVE: begin
          if (cnt_r != {CW{1'b0}}) begin
            cnt_nxt_s = cnt_r - CW'(1);
          end else begin
            state_nxt_s  = IDLE;
            in_nxt_s     = 1'b0;
            strobe_nxt_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s  = IDLE;
          in_nxt_s     = 1'b0;
          strobe_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= {SEL_WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      in         <= 1'b0;
      sel        <= {SEL_WIDTH{1'b0}};
      strobe     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ptr_r      <= ptr_nxt_s;
      cnt_r      <= cnt_nxt_s;
      in         <= in_nxt_s;
      sel        <= sel_nxt_s;
      strobe     <= strobe_nxt_s;
      frame_done <= frame_done_nxt_s;
    end
  end

endmodule
